// File: rtl/mod_setting_loader.sv
// Loads the modulation setting block (controller BRAM words 0x21..0x30) into
// shadow registers and presents it on the outputs as one coherent set.
module mod_setting_loader #(
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mod_set,
  output logic [7:0]  bram_addr,
  input  logic [15:0] bram_dout,
  output logic        req_rd_segment,
  output logic [15:0] cycle0,
  output logic [15:0] cycle1,
  output logic [31:0] freq_div0,
  output logic [31:0] freq_div1,
  output logic [31:0] rep0,
  output logic [31:0] rep1,
  output logic [7:0]  transition_mode,
  output logic [63:0] transition_value,
  output logic        update,
  output logic        busy
);

  localparam logic [7:0] ADDR_FIRST = 8'h21;
  localparam logic [7:0] ADDR_LAST  = 8'h30;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t                  state_r;
  logic                    mod_set_prev_r;
  logic                    pending_r;
  logic [READ_LATENCY-1:0] vld_pipe_r;
  logic [3:0]              idx_pipe_r [READ_LATENCY];
  logic [15:0]             shadow_r   [16];

  logic       trig_s;
  logic       cap_s;
  logic [3:0] cap_idx_s;
  logic       last_cap_s;

  // Word slots are indexed by the low address nibble: 0x21 -> 1 ... 0x30 -> 0.
  assign trig_s     = mod_set & ~mod_set_prev_r;
  assign cap_s      = vld_pipe_r[READ_LATENCY-1];
  assign cap_idx_s  = idx_pipe_r[READ_LATENCY-1];
  assign last_cap_s = cap_s && (cap_idx_s == 4'h0);

  // Address/valid pipeline matching the BRAM latency, and shadow capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe_r <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        idx_pipe_r[i] <= 4'h0;
      end
      for (int j = 0; j < 16; j++) begin
        shadow_r[j] <= 16'h0000;
      end
    end else begin
      vld_pipe_r[0] <= (state_r == READ);
      idx_pipe_r[0] <= bram_addr[3:0];
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_pipe_r[i] <= vld_pipe_r[i-1];
        idx_pipe_r[i] <= idx_pipe_r[i-1];
      end
      if (cap_s) begin
        shadow_r[cap_idx_s] <= bram_dout;
      end
    end
  end

  // Load sequencer with registered outputs; outputs change only out of COMMIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r          <= IDLE;
      mod_set_prev_r   <= 1'b0;
      pending_r        <= 1'b0;
      bram_addr        <= ADDR_FIRST;
      update           <= 1'b0;
      busy             <= 1'b0;
      req_rd_segment   <= 1'b0;
      cycle0           <= 16'hFFFF;
      cycle1           <= 16'hFFFF;
      freq_div0        <= 32'd10;
      freq_div1        <= 32'd10;
      rep0             <= 32'hFFFF_FFFF;
      rep1             <= 32'hFFFF_FFFF;
      transition_mode  <= 8'h00;
      transition_value <= 64'h0;
    end else begin
      mod_set_prev_r <= mod_set;
      update         <= 1'b0;
      case (state_r)
        IDLE: begin
          bram_addr <= ADDR_FIRST;
          if (trig_s) begin
            state_r   <= READ;
            pending_r <= 1'b0;
            busy      <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        READ: begin
          busy <= 1'b1;
          if (trig_s) begin
            pending_r <= 1'b1;
          end
          if (bram_addr == ADDR_LAST) begin
            state_r   <= DRAIN;
            bram_addr <= ADDR_FIRST;
          end else begin
            bram_addr <= bram_addr + 8'h01;
          end
        end
        DRAIN: begin
          busy      <= 1'b1;
          bram_addr <= ADDR_FIRST;
          if (trig_s) begin
            pending_r <= 1'b1;
          end
          if (last_cap_s) begin
            state_r <= COMMIT;
          end
        end
        COMMIT: begin
          bram_addr        <= ADDR_FIRST;
          update           <= 1'b1;
          req_rd_segment   <= shadow_r[1][0];
          cycle0           <= shadow_r[2];
          freq_div0        <= {shadow_r[4], shadow_r[3]};
          cycle1           <= shadow_r[5];
          freq_div1        <= {shadow_r[7], shadow_r[6]};
          rep0             <= {shadow_r[9], shadow_r[8]};
          rep1             <= {shadow_r[11], shadow_r[10]};
          transition_mode  <= shadow_r[12][7:0];
          transition_value <= {shadow_r[0], shadow_r[15], shadow_r[14], shadow_r[13]};
          // A trigger landing in this very cycle still earns a reload.
          if (pending_r || trig_s) begin
            state_r   <= READ;
            pending_r <= 1'b0;
            busy      <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          bram_addr <= ADDR_FIRST;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_setting_loader.sv
// Bench for mod_setting_loader: three instances (READ_LATENCY 1..3) sharing one
// BRAM image, each with its own latency-matched BRAM model.
module tb_mod_setting_loader;

  typedef struct packed {
    logic        req;
    logic [15:0] c0;
    logic [15:0] c1;
    logic [31:0] f0;
    logic [31:0] f1;
    logic [31:0] r0;
    logic [31:0] r1;
    logic [7:0]  tm;
    logic [63:0] tv;
  } set_t;

  localparam logic [15:0] SPEC_VEC [16] = '{
    16'h0001, 16'h0FFF, 16'h1388, 16'h0000, 16'h00FF, 16'h0000, 16'h0001, 16'h0005,
    16'h0000, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic mod_set;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  logic [15:0] mem [256];

  logic [7:0]  addr_a  [3];
  logic [15:0] dout_a  [3];
  logic        req_a   [3];
  logic [15:0] c0_a    [3];
  logic [15:0] c1_a    [3];
  logic [31:0] f0_a    [3];
  logic [31:0] f1_a    [3];
  logic [31:0] r0_a    [3];
  logic [31:0] r1_a    [3];
  logic [7:0]  tm_a    [3];
  logic [63:0] tv_a    [3];
  logic        upd_a   [3];
  logic        busy_a  [3];
  set_t        obs_a   [3];

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = g + 1;
    logic [15:0] st [L];

    always @(posedge clk) begin
      st[0] <= mem[addr_a[g]];
      for (int i = 1; i < L; i++) st[i] <= st[i-1];
    end
    assign dout_a[g] = st[L-1];
    assign obs_a[g]  = {req_a[g], c0_a[g], c1_a[g], f0_a[g], f1_a[g],
                        r0_a[g], r1_a[g], tm_a[g], tv_a[g]};

    mod_setting_loader #(.READ_LATENCY(L)) u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .mod_set          (mod_set),
      .bram_addr        (addr_a[g]),
      .bram_dout        (dout_a[g]),
      .req_rd_segment   (req_a[g]),
      .cycle0           (c0_a[g]),
      .cycle1           (c1_a[g]),
      .freq_div0        (f0_a[g]),
      .freq_div1        (f1_a[g]),
      .rep0             (r0_a[g]),
      .rep1             (r1_a[g]),
      .transition_mode  (tm_a[g]),
      .transition_value (tv_a[g]),
      .update           (upd_a[g]),
      .busy             (busy_a[g])
    );
  end

  // Monitor: update counts/times, snapshots of the L=2 instance, and output
  // changes that happen without an update pulse (reset edges excluded).
  int   upd_cnt [3] = '{0, 0, 0};
  int   upd_cyc [3] = '{0, 0, 0};
  int   stray   [3] = '{0, 0, 0};
  set_t prev_obs [3];
  set_t snap_q [$];
  int   snap_cyc_q [$];
  logic rst_edge = 1'b0;

  always @(posedge clk) rst_edge <= rst_n;

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (upd_a[g] === 1'b1) begin
        upd_cnt[g] <= upd_cnt[g] + 1;
        upd_cyc[g] <= cyc;
      end
      if (rst_edge === 1'b1 && upd_a[g] !== 1'b1 && obs_a[g] !== prev_obs[g])
        stray[g] <= stray[g] + 1;
      prev_obs[g] <= obs_a[g];
    end
    if (upd_a[1] === 1'b1) begin
      snap_q.push_back(obs_a[1]);
      snap_cyc_q.push_back(cyc);
    end
  end

  function automatic set_t defaults();
    set_t s;
    s.req = 1'b0;           s.c0 = 16'hFFFF;        s.c1 = 16'hFFFF;
    s.f0  = 32'd10;         s.f1 = 32'd10;
    s.r0  = 32'hFFFF_FFFF;  s.r1 = 32'hFFFF_FFFF;
    s.tm  = 8'h00;          s.tv = 64'h0;
    return s;
  endfunction

  // Reference: the setting set as the word map defines it, from the BRAM image.
  function automatic set_t model();
    set_t s;
    s.req = mem[8'h21][0];
    s.c0  = mem[8'h22];
    s.f0  = {mem[8'h24], mem[8'h23]};
    s.c1  = mem[8'h25];
    s.f1  = {mem[8'h27], mem[8'h26]};
    s.r0  = {mem[8'h29], mem[8'h28]};
    s.r1  = {mem[8'h2B], mem[8'h2A]};
    s.tm  = mem[8'h2C][7:0];
    s.tv  = {mem[8'h30], mem[8'h2F], mem[8'h2E], mem[8'h2D]};
    return s;
  endfunction

  task automatic fill_random();
    for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
  endtask

  task automatic pulse(output int k0);
    @(negedge clk);
    mod_set = 1'b1;
    k0 = cyc + 1;
    @(negedge clk);
    mod_set = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mod_set = 1'b0;
    fill_random();
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      n_cmp++;
      if (obs_a[g] !== defaults()) begin
        n_fail++;
        $display("FAIL reset_outputs[L=%0d]: got %h want %h", g + 1, obs_a[g], defaults());
      end
      n_cmp++;
      if ({busy_a[g], upd_a[g], addr_a[g]} !== {1'b0, 1'b0, 8'h21}) begin
        n_fail++;
        $display("FAIL reset_ctl[L=%0d]: busy/upd/addr got %b/%b/%h want 0/0/21",
                 g + 1, busy_a[g], upd_a[g], addr_a[g]);
      end
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (upd_cnt[1] !== 0 || busy_a[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: updates %0d busy %b want 0 0", upd_cnt[1], busy_a[1]);
    end
  endtask

  task automatic test_spec_vector();
    set_t exp;
    int   base [3];
    int   k0;
    for (int i = 0; i < 16; i++) mem[33 + i] = SPEC_VEC[i];
    exp.req = 1'b1;           exp.c0 = 16'h0FFF;       exp.c1 = 16'h00FF;
    exp.f0  = 32'h0000_1388;  exp.f1 = 32'h0001_0000;
    exp.r0  = 32'h0000_0005;  exp.r1 = 32'hFFFF_FFFF;
    exp.tm  = 8'h01;          exp.tv = 64'hDEF0_9ABC_5678_1234;
    for (int g = 0; g < 3; g++) base[g] = upd_cnt[g];
    pulse(k0);
    repeat (30) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      n_cmp++;
      if (upd_cnt[g] - base[g] !== 1) begin
        n_fail++;
        $display("FAIL spec_update_count[L=%0d]: got %0d want 1", g + 1, upd_cnt[g] - base[g]);
      end
      n_cmp++;
      if (upd_cyc[g] - k0 !== 18 + g) begin
        n_fail++;
        $display("FAIL spec_latency[L=%0d]: got %0d want %0d", g + 1, upd_cyc[g] - k0, 18 + g);
      end
      n_cmp++;
      if (obs_a[g] !== exp) begin
        n_fail++;
        $display("FAIL spec_outputs[L=%0d]: got %h want %h", g + 1, obs_a[g], exp);
      end
    end
  endtask

  task automatic test_random_loads();
    set_t exp;
    int   base;
    int   k0;
    for (int it = 0; it < 4; it++) begin
      fill_random();
      exp = model();
      base = upd_cnt[1];
      pulse(k0);
      repeat (30) @(negedge clk);
      n_cmp++;
      if (upd_cnt[1] - base !== 1 || upd_cyc[1] - k0 !== 19) begin
        n_fail++;
        $display("FAIL random_timing[%0d]: count %0d latency %0d want 1 19",
                 it, upd_cnt[1] - base, upd_cyc[1] - k0);
      end
      for (int g = 0; g < 3; g++) begin
        n_cmp++;
        if (obs_a[g] !== exp) begin
          n_fail++;
          $display("FAIL random_outputs[%0d][L=%0d]: got %h want %h", it, g + 1, obs_a[g], exp);
        end
      end
      n_cmp++;
      if (busy_a[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL random_busy_idle[%0d]: got %b want 0", it, busy_a[1]);
      end
    end
  endtask

  task automatic test_hold_level();
    int base [3];
    for (int g = 0; g < 3; g++) base[g] = upd_cnt[g];
    @(negedge clk);
    mod_set = 1'b1;
    repeat (100) @(negedge clk);
    mod_set = 1'b0;
    repeat (30) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      n_cmp++;
      if (upd_cnt[g] - base[g] !== 1) begin
        n_fail++;
        $display("FAIL hold_single_update[L=%0d]: got %0d want 1", g + 1, upd_cnt[g] - base[g]);
      end
    end
  endtask

  task automatic test_back_to_back();
    set_t exp_a;
    set_t exp_b;
    int   base;
    int   k0;
    int   k1;
    int   k2;
    fill_random();
    exp_a = model();
    base = upd_cnt[1];
    snap_q.delete();
    snap_cyc_q.delete();
    pulse(k0);
    repeat (3) @(negedge clk);
    pulse(k1);
    pulse(k2);
    // First load's reads are done; the pending load has not started reading.
    repeat (10) @(negedge clk);
    fill_random();
    exp_b = model();
    repeat (60) @(negedge clk);
    n_cmp++;
    if (upd_cnt[1] - base !== 2 || snap_q.size() !== 2) begin
      n_fail++;
      $display("FAIL b2b_update_count: got %0d (snaps %0d) want 2", upd_cnt[1] - base, snap_q.size());
    end
    if (snap_q.size() == 2) begin
      n_cmp++;
      if (snap_cyc_q[0] - k0 !== 19 || snap_cyc_q[1] - snap_cyc_q[0] !== 19) begin
        n_fail++;
        $display("FAIL b2b_timing: first %0d gap %0d want 19 19 (pulses at +%0d +%0d)",
                 snap_cyc_q[0] - k0, snap_cyc_q[1] - snap_cyc_q[0], k1 - k0, k2 - k0);
      end
      n_cmp++;
      if (snap_q[0] !== exp_a) begin
        n_fail++;
        $display("FAIL b2b_first_set: got %h want %h", snap_q[0], exp_a);
      end
      n_cmp++;
      if (snap_q[1] !== exp_b) begin
        n_fail++;
        $display("FAIL b2b_second_set: got %h want %h", snap_q[1], exp_b);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    int base [3];
    int k0;
    fill_random();
    for (int g = 0; g < 3; g++) base[g] = upd_cnt[g];
    pulse(k0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      n_cmp++;
      if (obs_a[g] !== defaults() || busy_a[g] !== 1'b0 || upd_a[g] !== 1'b0
          || addr_a[g] !== 8'h21) begin
        n_fail++;
        $display("FAIL abort_state[L=%0d]: out %h busy %b upd %b addr %h want %h 0 0 21",
                 g + 1, obs_a[g], busy_a[g], upd_a[g], addr_a[g], defaults());
      end
    end
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      n_cmp++;
      if (upd_cnt[g] - base[g] !== 0 || obs_a[g] !== defaults()) begin
        n_fail++;
        $display("FAIL abort_no_update[L=%0d]: updates %0d out %h want 0 %h",
                 g + 1, upd_cnt[g] - base[g], obs_a[g], defaults());
      end
    end
  endtask

  task automatic test_reset_release_high();
    set_t exp;
    int   base [3];
    int   k0;
    fill_random();
    exp = model();
    @(negedge clk);
    rst_n = 1'b0;
    mod_set = 1'b1;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) base[g] = upd_cnt[g];
    rst_n = 1'b1;
    k0 = cyc + 1;
    repeat (5) @(negedge clk);
    mod_set = 1'b0;
    repeat (30) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      n_cmp++;
      if (upd_cnt[g] - base[g] !== 1 || upd_cyc[g] - k0 !== 18 + g || obs_a[g] !== exp) begin
        n_fail++;
        $display("FAIL release_high[L=%0d]: count %0d latency %0d out %h want 1 %0d %h",
                 g + 1, upd_cnt[g] - base[g], upd_cyc[g] - k0, obs_a[g], 18 + g, exp);
      end
    end
  endtask

  task automatic test_no_early_change();
    for (int g = 0; g < 3; g++) begin
      n_cmp++;
      if (stray[g] !== 0) begin
        n_fail++;
        $display("FAIL output_change_without_update[L=%0d]: got %0d want 0", g + 1, stray[g]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_spec_vector();
    test_random_loads();
    test_hold_level();
    test_back_to_back();
    test_reset_mid_load();
    test_reset_release_high();
    test_no_early_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mod_setting_loader.md
MOD_SETTING_LOADER -- requirements
Module: mod_setting_loader

Interface
REQ-001 Parameter READ_LATENCY, default 2, SHALL set the controller BRAM read latency in cycles (legal 1..3).
REQ-002 CLK  in  1  SHALL be the single system clock; all logic is rising-edge.
REQ-003 RST_N  in  1  SHALL be the synchronous, active-low reset, sampled on the CLK rising edge.
REQ-004 MOD_SET  in  1  SHALL be the ctl-flag bit CTL_FLAG_BIT_MOD_SET (bit 0 of ADDR_CTL_FLAG), as a level.
REQ-005 BRAM_ADDR  out  8  SHALL be the controller-BRAM word read address.
REQ-006 BRAM_DOUT  in  16  SHALL be the controller-BRAM read data, valid READ_LATENCY cycles after BRAM_ADDR.
REQ-007 REQ_RD_SEGMENT  out  1  SHALL be bit 0 of ADDR_MOD_REQ_RD_SEGMENT (0x21).
REQ-008 CYCLE0, CYCLE1  out  16 each  SHALL be words 0x22 and 0x25.
REQ-009 FREQ_DIV0, FREQ_DIV1  out  32 each  SHALL be {0x24,0x23} and {0x27,0x26}, low word at the lower address.
REQ-010 REP0, REP1  out  32 each  SHALL be {0x29,0x28} and {0x2B,0x2A}.
REQ-011 TRANSITION_MODE  out  8  SHALL be bits [7:0] of 0x2C.
REQ-012 TRANSITION_VALUE  out  64  SHALL be {0x30,0x2F,0x2E,0x2D}.
REQ-013 UPDATE  out  1  SHALL pulse high for one cycle when a new coherent setting set is presented.
REQ-014 BUSY  out  1  SHALL be high whenever the FSM is not IDLE.

Function
REQ-015 Trigger: a 0->1 transition of MOD_SET, sampled as current vs previous-cycle registered value, SHALL start a load; a held-high level SHALL NOT retrigger.
REQ-016 FSM states SHALL be IDLE, READ, DRAIN, COMMIT: IDLE->READ on trigger; READ->DRAIN after the last address; DRAIN->COMMIT after the last word is captured; COMMIT->IDLE, or COMMIT->READ if pending is set.
REQ-017 READ SHALL issue addresses 0x21..0x30 in ascending order, one per cycle, for 16 consecutive cycles.
REQ-018 Data SHALL be captured READ_LATENCY cycles after its address, via a READ_LATENCY-deep address/valid shift pipeline, into shadow registers.
REQ-019 Only shadow registers SHALL be written during READ and DRAIN; all outputs SHALL update together in COMMIT, with UPDATE high in that same cycle.
REQ-020 Latency SHALL be fixed: from the trigger-sample cycle, UPDATE asserts exactly 16 + READ_LATENCY + 1 cycles later (19 for default).
REQ-021 Unused upper bits of 0x21 (bits [15:1]) and 0x2C (bits [15:8]) SHALL be ignored.
REQ-022 A trigger while BUSY SHALL set a one-deep pending flag; further triggers while pending is set SHALL be absorbed, and the flag SHALL clear on entering READ.
REQ-023 A trigger in the COMMIT cycle SHALL count as pending, not be lost.
REQ-024 BRAM_ADDR SHALL hold 0x21 when not in READ.
REQ-025 No arithmetic SHALL be performed; words are concatenated without sign extension or truncation beyond REQ-021.

Reset
REQ-026 With RST_N low at a clock edge: FSM to IDLE; pending and edge register cleared; UPDATE=0; BUSY=0; BRAM_ADDR=0x21.
REQ-027 With RST_N low: outputs SHALL reset to CYCLE0=CYCLE1=0xFFFF, FREQ_DIV0=FREQ_DIV1=10, REP0=REP1=0xFFFFFFFF, TRANSITION_MODE=0x00 (SYNC_IDX), TRANSITION_VALUE=0, REQ_RD_SEGMENT=0.
REQ-028 Reset mid-load SHALL abort without any UPDATE and without altering any output beyond REQ-027.
REQ-029 The edge register SHALL reset to 0, so MOD_SET already high on reset release SHALL trigger one load.

Verification
REQ-030 BRAM preloaded 0x21..0x30 = 0x0001,0x0FFF,0x1388,0x0000,0x00FF,0x0000,0x0001,0x0005,0x0000,0xFFFF,0xFFFF,0x0001,0x1234,0x5678,0x9ABC,0xDEF0; pulse MOD_SET -> after 19 cycles one UPDATE with REQ_RD_SEGMENT=1, CYCLE0=0x0FFF, FREQ_DIV0=0x00001388, CYCLE1=0x00FF, FREQ_DIV1=0x00010000, REP0=5, REP1=0xFFFFFFFF, TRANSITION_MODE=0x01, TRANSITION_VALUE=0xDEF09ABC56781234.
REQ-031 Hold MOD_SET high for 100 cycles -> exactly one UPDATE.
REQ-032 Two MOD_SET pulses 5 cycles apart, plus a third 2 cycles later -> exactly two UPDATEs, the second 19 cycles after the first COMMIT; the second load reflects BRAM rewritten between pulses.
REQ-033 RST_N low at cycle 10 of a load -> no UPDATE, outputs equal REQ-027 values, BUSY=0 next cycle.
REQ-034 Sweep READ_LATENCY over 1, 2 and 3 with the REQ-030 data -> identical outputs, UPDATE at 18, 19 and 20 cycles respectively.
REQ-035 Check outputs every cycle during a load -> no output changes before the UPDATE cycle.
